// File: rtl/ucode_seq_pkg.sv
// Shared microcode definitions: ROM word layout, entry points,
// register-field positions and the sequencer state encoding.
package ucode_seq_pkg;

    localparam int NUPCMSB = 4;

    localparam logic [NUPCMSB:0] UPC_TRAP = 5'd0;
    localparam logic [NUPCMSB:0] UPC_ST   = 5'd4;
    localparam logic [NUPCMSB:0] UPC_SWAP = 5'd8;

    localparam int UCIPOS_RD  = 25;
    localparam int UCIPOS_RS1 = 14;
    localparam int UCIPOS_RS2 = 0;
    localparam int UCIPOS_I   = 13;

    localparam logic [4:0] UCI_MASK = 5'b10000;

    typedef struct packed {
        logic        uend;
        logic        cwp_rs1;
        logic        cwp_rd;
        logic [31:0] inst;
    } microcode_out_type;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
    } ucode_seq_state_type;

    // Five-bit select mask: all ones when the field asks for indirection.
    function automatic logic [4:0] field_sel(input logic [4:0] f);
        return ((f & UCI_MASK) != 5'd0) ? 5'b11111 : 5'b00000;
    endfunction

endpackage

// File: rtl/ucode_field_resolve.sv
// Register-field indirection: masked rd/rs1/rs2 fields of a ROM word
// are replaced by the matching fields of the captured macro instruction.
module ucode_field_resolve
    import ucode_seq_pkg::*;
(
    input  logic [31:0] rom_inst_i,
    input  logic [31:0] orig_inst_i,
    output logic [31:0] res_inst_o
);

    logic [31:0] sel;

    // Build a per-bit select; rs2 only when the i bit marks a register form.
    always_comb begin
        sel = '0;
        sel[UCIPOS_RD+:5]  = field_sel(rom_inst_i[UCIPOS_RD+:5]);
        sel[UCIPOS_RS1+:5] = field_sel(rom_inst_i[UCIPOS_RS1+:5]);
        if (!rom_inst_i[UCIPOS_I]) begin
            sel[UCIPOS_RS2+:5] = field_sel(rom_inst_i[UCIPOS_RS2+:5]);
        end
        res_inst_o = (rom_inst_i & ~sel) | (orig_inst_i & sel);
    end

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer: walks ROM words from a start micro-PC and issues
// resolved micro-ops. Optional sequence-length watchdog: UCODE_WATCHDOG_EN.
module ucode_seq
    import ucode_seq_pkg::*;
#(
    parameter int MAXLEN = 8
) (
    input  logic              gclk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [NUPCMSB:0]  start_upc,
    input  logic [31:0]       orig_inst,
    input  logic              kill,
    output logic [NUPCMSB:0]  rom_addr,
    input  microcode_out_type rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic              out_cwp_rs1,
    output logic              out_cwp_rd,
    output logic              out_last,
    output logic              ucode_err
);

    if (MAXLEN < 2) begin : g_bad_maxlen
        $error("MAXLEN must be at least 2");
    end

    ucode_seq_state_type state_q, state_d;
    logic [NUPCMSB:0] upc_q, upc_d;
    logic [31:0]      orig_q, orig_d;
    logic [31:0]      inst_q, inst_d;
    logic             cwp_rs1_q, cwp_rs1_d;
    logic             cwp_rd_q, cwp_rd_d;
    logic             last_q, last_d;
    logic [31:0]      res_inst;
    logic             start_acc;
    logic             hs;
    logic             wd_hit;

    ucode_field_resolve u_resolve (
        .rom_inst_i  (rom_data.inst),
        .orig_inst_i (orig_q),
        .res_inst_o  (res_inst)
    );

    assign start_ready = (state_q == IDLE) && !kill;
    assign out_valid   = (state_q == ISSUE);
    assign start_acc   = start_valid && start_ready;
    assign hs          = out_valid && out_ready;
    assign out_inst    = inst_q;
    assign out_cwp_rs1 = cwp_rs1_q;
    assign out_cwp_rd  = cwp_rd_q;
    assign out_last    = last_q;

`ifdef UCODE_WATCHDOG_EN
    localparam int CW = $clog2(MAXLEN) + 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count issue handshakes within the current sequence.
    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Per-sequence handshake counter register.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wd_hit = (cnt_q == CW'(MAXLEN - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // Next-state, ROM address and error decode; kill overrides all.
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        orig_d    = orig_q;
        inst_d    = inst_q;
        cwp_rs1_d = cwp_rs1_q;
        cwp_rd_d  = cwp_rd_q;
        last_d    = last_q;
        rom_addr  = upc_q;
        ucode_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                rom_addr = start_upc;
                if (start_acc) begin
                    upc_d   = start_upc;
                    orig_d  = orig_inst;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                inst_d    = res_inst;
                cwp_rs1_d = rom_data.cwp_rs1;
                cwp_rd_d  = rom_data.cwp_rd;
                last_d    = rom_data.uend;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (hs) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        rom_addr = upc_q + 1'b1;
                        if (upc_q == '1 || wd_hit) begin
                            ucode_err = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            upc_d   = upc_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d   = IDLE;
            ucode_err = 1'b0;
        end
    end

    // Sequencer state, micro-PC, captured instruction and issue registers.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            upc_q     <= '0;
            orig_q    <= '0;
            inst_q    <= '0;
            cwp_rs1_q <= 1'b0;
            cwp_rd_q  <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            orig_q    <= orig_d;
            inst_q    <= inst_d;
            cwp_rs1_q <= cwp_rs1_d;
            cwp_rd_q  <= cwp_rd_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq with a synchronous ROM model.
// Watchdog scenario runs only when UCODE_WATCHDOG_EN is defined.
module tb_ucode_seq;
    import ucode_seq_pkg::*;

    logic              gclk = 1'b0;
    logic              rst = 1'b1;
    logic              start_valid = 1'b0;
    logic              start_ready;
    logic [NUPCMSB:0]  start_upc = '0;
    logic [31:0]       orig_inst = '0;
    logic              kill = 1'b0;
    logic [NUPCMSB:0]  rom_addr;
    microcode_out_type rom_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_inst;
    logic              out_cwp_rs1;
    logic              out_cwp_rd;
    logic              out_last;
    logic              ucode_err;

    int checks = 0;
    int errors = 0;

    microcode_out_type rom [0:31];

    ucode_seq #(.MAXLEN(8)) dut (
        .gclk        (gclk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_upc   (start_upc),
        .orig_inst   (orig_inst),
        .kill        (kill),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_cwp_rs1 (out_cwp_rs1),
        .out_cwp_rd  (out_cwp_rd),
        .out_last    (out_last),
        .ucode_err   (ucode_err)
    );

    always #5 gclk = ~gclk;

    always @(posedge gclk) rom_data <= rom[rom_addr];

    function automatic microcode_out_type mkw(input logic ue, input logic c1,
                                              input logic cd, input logic [31:0] in);
        microcode_out_type w;
        w.uend = ue;
        w.cwp_rs1 = c1;
        w.cwp_rd = cd;
        w.inst = in;
        return w;
    endfunction

    task automatic start_seq(input logic [4:0] upc, input logic [31:0] oi);
        start_upc = upc;
        orig_inst = oi;
        start_valid = 1'b1;
        @(posedge gclk);
        #1;
        start_valid = 1'b0;
        start_upc = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge gclk);
        @(negedge gclk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rst_start_ready: got %b expected 1", start_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst: got %h expected 0", out_inst); end
        checks++; if ({out_cwp_rs1, out_cwp_rd, out_last} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {out_cwp_rs1, out_cwp_rd, out_last}); end
        checks++; if (ucode_err !== 1'b0) begin errors++; $display("FAIL rst_ucode_err: got %b expected 0", ucode_err); end
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL rst_rom_addr: got %h expected 0", rom_addr); end
        @(posedge gclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_st_subst;
        logic [31:0] exp;
        rom[4] = mkw(1'b1, 1'b0, 1'b1, {2'b11, 5'b10000, 6'b000100, 5'b00011, 1'b0, 8'h00, 5'b00001});
        exp = {2'b11, 5'd7, 6'b000100, 5'd3, 1'b0, 8'h00, 5'd1};
        out_ready = 1'b1;
        start_seq(UPC_ST, {2'b10, 5'd7, 6'h3f, 5'd31, 1'b0, 8'hff, 5'd31});
        @(negedge gclk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_fetch_valid: got %b expected 0", out_valid); end
        checks++; if (rom_addr !== 5'd4) begin errors++; $display("FAIL st_fetch_addr: got %h expected 4", rom_addr); end
        @(posedge gclk);
        #1;
        @(negedge gclk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_valid: got %b expected 1", out_valid); end
        checks++; if (out_inst !== exp) begin errors++; $display("FAIL st_inst: got %h expected %h", out_inst, exp); end
        checks++; if ({out_cwp_rs1, out_cwp_rd, out_last} !== 3'b011) begin errors++; $display("FAIL st_flags: got %b expected 011", {out_cwp_rs1, out_cwp_rd, out_last}); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL st_busy: got %b expected 0", start_ready); end
        @(posedge gclk);
        #1;
        @(negedge gclk);
        checks++; if (start_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL st_done: got ready %b valid %b expected 1 0", start_ready, out_valid); end
    endtask

    task automatic test_trap_seq;
        int nv;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) rom[i] = mkw(i == 3, 1'b0, 1'b0, 32'h0100_0020 | (32'(i) << 1));
        out_ready = 1'b1;
        start_seq(UPC_TRAP, 32'hffff_ffff);
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge gclk);
            if (c < 8 && c % 2 == 0) begin
                checks++; if (rom_addr !== 5'(c / 2)) begin errors++; $display("FAIL trap_rom_addr: got %h expected %h", rom_addr, 5'(c / 2)); end
            end
            if (out_valid) begin
                exp = 32'h0100_0020 | (32'(nv) << 1);
                checks++; if (c != 2 * nv + 1) begin errors++; $display("FAIL trap_timing: got slot %0d expected %0d", c, 2 * nv + 1); end
                checks++; if (out_inst !== exp) begin errors++; $display("FAIL trap_inst: got %h expected %h", out_inst, exp); end
                checks++; if (out_last !== (nv == 3)) begin errors++; $display("FAIL trap_last: got %b expected %b", out_last, nv == 3); end
                if (nv < 3) begin
                    checks++; if (rom_addr !== 5'(nv + 1)) begin errors++; $display("FAIL trap_next_addr: got %h expected %h", rom_addr, 5'(nv + 1)); end
                end
                nv++;
            end
            @(posedge gclk);
            #1;
        end
        checks++; if (nv != 4) begin errors++; $display("FAIL trap_count: got %0d expected 4", nv); end
    endtask

    task automatic test_imm_gating;
        logic [31:0] w;
        w = {2'b10, 5'b00010, 6'b000000, 5'b00001, 1'b1, 13'h1010};
        rom[10] = mkw(1'b1, 1'b1, 1'b0, w);
        out_ready = 1'b1;
        start_seq(5'd10, {27'h7ff_ffff, 5'd5});
        @(posedge gclk);
        #1;
        @(negedge gclk);
        checks++; if (out_inst !== w) begin errors++; $display("FAIL imm_inst: got %h expected %h", out_inst, w); end
        checks++; if (out_cwp_rs1 !== 1'b1) begin errors++; $display("FAIL imm_cwp_rs1: got %b expected 1", out_cwp_rs1); end
        @(posedge gclk);
        #1;
    endtask

    task automatic test_backpressure_kill;
        logic [31:0] exp;
        rom[8] = mkw(1'b0, 1'b0, 1'b0, {2'b01, 5'b00100, 6'b001000, 5'b10010, 1'b0, 8'h0f, 5'b00110});
        exp = {2'b01, 5'b00100, 6'b001000, 5'd9, 1'b0, 8'h0f, 5'b00110};
        out_ready = 1'b0;
        start_seq(UPC_SWAP, {13'h0, 5'd9, 14'h0});
        @(posedge gclk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge gclk);
            checks++; if (out_valid !== 1'b1 || out_inst !== exp) begin errors++; $display("FAIL bp_hold: got valid %b inst %h expected 1 %h", out_valid, out_inst, exp); end
            checks++; if (rom_addr !== 5'd8) begin errors++; $display("FAIL bp_addr: got %h expected 08", rom_addr); end
            @(posedge gclk);
            #1;
        end
        kill = 1'b1;
        out_ready = 1'b1;
        @(negedge gclk);
        checks++; if (ucode_err !== 1'b0 || start_ready !== 1'b0) begin errors++; $display("FAIL kill_cycle: got err %b ready %b expected 0 0", ucode_err, start_ready); end
        @(posedge gclk);
        #1;
        start_valid = 1'b1;
        start_upc = UPC_ST;
        @(negedge gclk);
        checks++; if (out_valid !== 1'b0 || start_ready !== 1'b0) begin errors++; $display("FAIL kill_idle: got valid %b ready %b expected 0 0", out_valid, start_ready); end
        @(posedge gclk);
        #1;
        kill = 1'b0;
        start_valid = 1'b0;
        start_upc = '0;
        @(negedge gclk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL kill_start_rejected: got ready %b expected 1", start_ready); end
    endtask

    task automatic test_wrap;
        int nv;
        rom[31] = mkw(1'b0, 1'b0, 1'b0, 32'h8000_0001);
        out_ready = 1'b1;
        start_seq(5'd31, 32'h0);
        @(posedge gclk);
        #1;
        @(negedge gclk);
        checks++; if (out_valid !== 1'b1 || ucode_err !== 1'b1) begin errors++; $display("FAIL wrap_err: got valid %b err %b expected 1 1", out_valid, ucode_err); end
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge gclk);
            #1;
            @(negedge gclk);
            if (out_valid || ucode_err) nv++;
        end
        checks++; if (nv != 0 || start_ready !== 1'b1) begin errors++; $display("FAIL wrap_stop: got %0d extra ready %b expected 0 1", nv, start_ready); end
        start_seq(5'd31, 32'h0);
        @(posedge gclk);
        #1;
        kill = 1'b1;
        @(negedge gclk);
        checks++; if (ucode_err !== 1'b0) begin errors++; $display("FAIL wrap_kill_err: got %b expected 0", ucode_err); end
        @(posedge gclk);
        #1;
        kill = 1'b0;
        @(negedge gclk);
        checks++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL wrap_kill_idle: got valid %b ready %b expected 0 1", out_valid, start_ready); end
    endtask

`ifdef UCODE_WATCHDOG_EN
    task automatic test_watchdog;
        int nv;
        for (int i = 16; i < 32; i++) rom[i] = mkw(1'b0, 1'b0, 1'b0, 32'h0000_0100 + 32'(i));
        out_ready = 1'b1;
        start_seq(5'd16, 32'h0);
        nv = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge gclk);
            if (out_valid) begin
                nv++;
                checks++; if (ucode_err !== (nv == 8)) begin errors++; $display("FAIL wd_err: got %b expected %b at op %0d", ucode_err, nv == 8, nv); end
            end
            @(posedge gclk);
            #1;
        end
        checks++; if (nv != 8 || start_ready !== 1'b1) begin errors++; $display("FAIL wd_count: got %0d ready %b expected 8 1", nv, start_ready); end
    endtask
`endif

    task automatic test_async_reset;
        out_ready = 1'b0;
        start_seq(UPC_TRAP, 32'h1234_5678);
        @(posedge gclk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL arst_ctl: got valid %b ready %b expected 0 1", out_valid, start_ready); end
        checks++; if (out_inst !== 32'h0 || {out_cwp_rs1, out_cwp_rd, out_last, ucode_err} !== 4'b0) begin errors++; $display("FAIL arst_out: got %h %b expected 0", out_inst, {out_cwp_rs1, out_cwp_rd, out_last, ucode_err}); end
        @(posedge gclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = '0;
        test_reset();
        test_st_subst();
        test_trap_seq();
        test_imm_gating();
        test_backpressure_kill();
        test_wrap();
`ifdef UCODE_WATCHDOG_EN
        test_watchdog();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
